// File: rtl/mem_port_arbiter_if.sv
// Request/done handshakes for fetch and data paths plus the shared memory bus.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              dm_req;
  logic              dm_read_wrn;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              mem_en;
  logic              mem_read_wrn;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_err;
  logic              stall;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_read_wrn, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, dm_rdata, dm_done, mem_en, mem_read_wrn, mem_addr, mem_wdata,
           bus_err, stall
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_read_wrn, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, dm_rdata, dm_done, mem_en, mem_read_wrn, mem_addr, mem_wdata,
           bus_err, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, data first,
// with a fetch starvation guard and a bus-timeout watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_read_wrn_q, mem_read_wrn_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              bus_err_q, bus_err_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic pick_dm, pick_if, in_gnt, wd_hit, finish;

  // Arbitration and access-completion decode
  always_comb begin
    pick_dm = bus.dm_req && (!bus.if_req || (starve_q < SC_W'(STARVE_LIMIT)));
    pick_if = bus.if_req && !pick_dm;
    in_gnt  = (state_q == GNT_IF) || (state_q == GNT_DM);
    wd_hit  = (TIMEOUT != 0) && in_gnt && !bus.mem_ready && (wd_q == WD_W'(TIMEOUT));
    finish  = in_gnt && (bus.mem_ready || wd_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_dm)      state_d = GNT_DM;
        else if (pick_if) state_d = GNT_IF;
      end
      GNT_IF, GNT_DM: if (finish) state_d = DONE;
      DONE:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en_d       = mem_en_q;
    mem_read_wrn_d = mem_read_wrn_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    if_rdata_d     = if_rdata_q;
    dm_rdata_d     = dm_rdata_q;
    starve_d       = starve_q;
    wd_d           = wd_q;
    if_done_d      = 1'b0;
    dm_done_d      = 1'b0;
    bus_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_dm) begin
          mem_en_d       = 1'b1;
          mem_read_wrn_d = bus.dm_read_wrn;
          mem_addr_d     = bus.dm_addr;
          mem_wdata_d    = bus.dm_wdata;
          if (!bus.if_req)                          starve_d = '0;
          else if (starve_q < SC_W'(STARVE_LIMIT))  starve_d = starve_q + SC_W'(1);
        end else if (pick_if) begin
          mem_en_d       = 1'b1;
          mem_read_wrn_d = 1'b1;
          mem_addr_d     = bus.if_addr;
          starve_d       = '0;
        end
      end
      GNT_IF, GNT_DM: begin
        wd_d = wd_q + WD_W'(1);
        if (finish) begin
          mem_en_d  = 1'b0;
          bus_err_d = wd_hit;
          if (state_q == GNT_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = wd_hit ? ABORT_DATA : bus.mem_rdata;
          end else begin
            dm_done_d = 1'b1;
            // A store leaves the load-data register untouched
            if (mem_read_wrn_q) dm_rdata_d = wd_hit ? ABORT_DATA : bus.mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q       <= 1'b0;
      mem_read_wrn_q <= 1'b1;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      if_rdata_q     <= '0;
      dm_rdata_q     <= '0;
      if_done_q      <= 1'b0;
      dm_done_q      <= 1'b0;
      bus_err_q      <= 1'b0;
      starve_q       <= '0;
      wd_q           <= '0;
    end else begin
      mem_en_q       <= mem_en_d;
      mem_read_wrn_q <= mem_read_wrn_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      if_rdata_q     <= if_rdata_d;
      dm_rdata_q     <= dm_rdata_d;
      if_done_q      <= if_done_d;
      dm_done_q      <= dm_done_d;
      bus_err_q      <= bus_err_d;
      starve_q       <= starve_d;
      wd_q           <= wd_d;
    end
  end

  assign bus.mem_en       = mem_en_q;
  assign bus.mem_read_wrn = mem_read_wrn_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.dm_rdata     = dm_rdata_q;
  assign bus.if_done      = if_done_q;
  assign bus.dm_done      = dm_done_q;
  assign bus.bus_err      = bus_err_q;
  // Pipeline halt while any request is still waiting for its done pulse
  assign bus.stall = !rst && ((bus.if_req && !if_done_q) || (bus.dm_req && !dm_done_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses, starvation order, watchdog, reset.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Memory model: configurable wait states, or never ready when hung
  int unsigned mem_wait;
  int unsigned wait_left;
  bit          mem_hang;
  bit          mem_busy;

  function automatic logic [31:0] rd_fn(input logic [15:0] a);
    return (a == 16'h0010) ? 32'h0000_0013 : {16'hC0DE, a};
  endfunction

  always @(posedge clk) begin
    #2;
    bus.mem_ready = 1'b0;
    if (rst || !bus.mem_en) mem_busy = 1'b0;
    else if (!mem_hang) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        wait_left = mem_wait;
      end
      if (wait_left == 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd_fn(bus.mem_addr);
        mem_busy      = 1'b0;
      end else wait_left--;
    end
  end

  // Monitor: every done pulse retires one scoreboard entry
  always @(negedge clk) begin
    if (!rst && (bus.if_done || bus.dm_done)) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got if_done=%b dm_done=%b expected none", bus.if_done, bus.dm_done);
      end else begin
        e = sb.pop_front();
        check("done_port", 32'({bus.if_done, bus.dm_done}), e.is_dm ? 32'd1 : 32'd2);
        check("rdata", e.is_dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
        check("bus_err", 32'(bus.bus_err), 32'(e.err));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    check({tag, "_mem_read_wrn"}, 32'(bus.mem_read_wrn), 32'd1);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
    check({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
    check({tag, "_dones"}, 32'({bus.if_done, bus.dm_done}), 32'd0);
    check({tag, "_bus_err"}, 32'(bus.bus_err), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
  endtask

  // One access from a single requester; called at posedge+1 with the arbiter idle
  task automatic issue(input string tag, input bit is_dm, input bit rd, input logic [15:0] a,
                       input logic [31:0] wd, input int unsigned wt, input bit hang,
                       input logic [31:0] exp_rd, input bit exp_err,
                       output int unsigned lat, output int unsigned en_cyc);
    bit bus_ok;
    exp_t x;
    mem_wait = wt;
    mem_hang = hang;
    x.is_dm = is_dm; x.rdata = exp_rd; x.err = exp_err;
    sb.push_back(x);
    if (is_dm) begin
      bus.dm_req = 1'b1; bus.dm_read_wrn = rd; bus.dm_addr = a; bus.dm_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    lat = 0; en_cyc = 0; bus_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_en) begin
        en_cyc++;
        if (bus.mem_addr !== a || bus.mem_read_wrn !== (is_dm ? rd : 1'b1) ||
            (is_dm && !rd && bus.mem_wdata !== wd) || bus.stall !== 1'b1) bus_ok = 1'b0;
      end
    end while (!(is_dm ? bus.dm_done : bus.if_done) && lat < 200);
    check({tag, "_bus_stable"}, 32'(bus_ok), 32'd1);
    check({tag, "_stall_in_done"}, 32'(bus.stall), 32'd0);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  int unsigned lat, en_cyc, n, quiet_err;

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_read_wrn = 1'b1; bus.dm_addr = '0; bus.dm_wdata = '0;
    mem_wait = 0; mem_hang = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("init");
    rst = 1'b0;
    @(posedge clk); #1;

    issue("fetch", 1'b0, 1'b1, 16'h0010, 32'h0, 0, 1'b0, 32'h0000_0013, 1'b0, lat, en_cyc);
    check("fetch_latency", lat, 32'd2);
    check("fetch_en_cycles", en_cyc, 32'd1);

    issue("load", 1'b1, 1'b1, 16'h0300, 32'h0, 1, 1'b0, 32'hC0DE_0300, 1'b0, lat, en_cyc);
    check("load_latency", lat, 32'd3);
    check("load_en_cycles", en_cyc, 32'd2);

    issue("store", 1'b1, 1'b0, 16'h0200, 32'hCAFE_F00D, 3, 1'b0, 32'hC0DE_0300, 1'b0, lat, en_cyc);
    check("store_latency", lat, 32'd5);
    check("store_en_cycles", en_cyc, 32'd4);

    issue("wd_fetch", 1'b0, 1'b1, 16'h0020, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 1'b1, lat, en_cyc);
    check("wd_fetch_latency", lat, 32'd10);
    check("wd_fetch_en_cycles", en_cyc, 32'd9);

    issue("wd_store", 1'b1, 1'b0, 16'h0240, 32'h1234_5678, 0, 1'b1, 32'hC0DE_0300, 1'b1, lat, en_cyc);
    check("wd_store_latency", lat, 32'd10);
    check("wd_store_en_cycles", en_cyc, 32'd9);

    // Both requesters held: four data grants, then one fetch, repeating
    mem_wait = 0; mem_hang = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e.is_dm = (i % 5) != 4;
      e.rdata = e.is_dm ? 32'hC0DE_0400 : 32'hC0DE_0100;
      e.err   = 1'b0;
      sb.push_back(e);
    end
    bus.if_req = 1'b1; bus.if_addr = 16'h0100;
    bus.dm_req = 1'b1; bus.dm_read_wrn = 1'b1; bus.dm_addr = 16'h0400;
    n = 0; lat = 0;
    while (n < 10 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.if_done || bus.dm_done) n++;
    end
    check("starve_done_count", n, 32'd10);
    check("starve_latency", lat, 32'd29);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a hung load
    mem_hang = 1'b1;
    bus.dm_req = 1'b1; bus.dm_read_wrn = 1'b1; bus.dm_addr = 16'h0500;
    repeat (3) @(posedge clk);
    #1;
    check("mid_stall_busy", 32'(bus.stall), 32'd1);
    check("mid_mem_en", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_stall_in_rst", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    check_reset("mid_rst");
    rst = 1'b0;
    bus.dm_req = 1'b0;
    mem_hang = 1'b0;
    quiet_err = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.bus_err || bus.mem_en) quiet_err++;
    end
    check("post_rst_quiet", quiet_err, 32'd0);

    issue("post_rst_load", 1'b1, 1'b1, 16'h0600, 32'h0, 0, 1'b0, 32'hC0DE_0600, 1'b0, lat, en_cyc);
    check("post_rst_latency", lat, 32'd2);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
